// File: rtl/popcount_classifier.sv
// popcount_classifier
// Counts the set bits of an accepted word K bits per cycle and classifies
// the final count according to a 2-bit mode latched with the word.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - producer offers in_data/in_sel
//   in_ready   - block can accept a word (IDLE only)
//   in_data    - W-bit word to count
//   in_sel     - classification mode: 0 zero, 1 power of two,
//                2 other nonzero below W, 3 all ones
//   out_valid  - out_count/out_match hold a result
//   out_ready  - consumer takes the result this cycle
//   out_count  - number of set bits in the accepted word
//   out_match  - count belongs to the selected class
//   busy       - a word is being counted or awaiting drain
module popcount_classifier #(
  parameter  int unsigned W  = 7,
  parameter  int unsigned K  = 1,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_match,
  output logic          busy
);

  localparam int unsigned NCHUNK = (W + K - 1) / K;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [CW-1:0] W_C      = CW'(W);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q,  data_d;
  logic [1:0]    sel_q,   sel_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [CW-1:0] acc_q,   acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          match_q, match_d;
  logic          valid_q, valid_d;

  int unsigned   shamt;
  logic [K-1:0]  chunk;
  logic [CW-1:0] chunk_pop;
  logic [CW-1:0] sum;

  function automatic logic [CW-1:0] pop_k(input logic [K-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned b = 0; b < K; b++) begin
      n = n + CW'(v[b]);
    end
    return n;
  endfunction

  function automatic logic classify(input logic [CW-1:0] c, input logic [1:0] sel);
    logic nz;
    logic pow2;
    logic r;
    nz   = (c != '0);
    pow2 = nz && ((c & (c - CW'(1))) == '0);
    case (sel)
      2'd0:    r = !nz;
      2'd1:    r = pow2;
      2'd2:    r = nz && !pow2 && (c < W_C);
      default: r = (c == W_C);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    match_d = match_q;
    valid_d = valid_q;

    // Right shift zero-fills above bit W-1, so the final partial chunk is
    // masked without a separate padding step.
    shamt     = 32'(idx_q) * K;
    chunk     = K'(data_q >> shamt);
    chunk_pop = pop_k(chunk);
    sum       = acc_q + chunk_pop;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          sel_d   = in_sel;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d = sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          count_d = sum;
          match_d = classify(sum, sel_q);
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      match_q <= match_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_match = match_q;

endmodule

// File: doc/popcount_classifier.md
POPCOUNT_CLASSIFIER -- requirements
Module: popcount_classifier

Interface
REQ-001 Parameter W, default 7: input word width in bits, legal range 1..64.
REQ-002 Parameter K, default 1: bits examined per cycle, legal range 1..W.
REQ-003 Derived localparam CW = clog2(W+1): count width.
REQ-004 Derived localparam NCHUNK = ceil(W/K): count cycles per word.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 in_valid  input  1  producer offers in_data/in_sel.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  W  word whose set bits are counted.
REQ-010 in_sel  input  2  classification mode for this word.
REQ-011 out_valid  output  1  out_count/out_match hold a result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_count  output  CW  number of 1 bits in the accepted word.
REQ-014 out_match  output  1  count belongs to the class selected by the latched in_sel.
REQ-015 busy  output  1  high in COUNT or DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-017 in_ready SHALL be high in IDLE only, and SHALL be low in COUNT and DONE.
REQ-018 Accept occurs when in_valid and in_ready are both high at the clock edge; in_data and in_sel SHALL be latched, the accumulator SHALL be cleared, the chunk index SHALL be set to 0, and the state SHALL become COUNT.
REQ-019 Each COUNT cycle SHALL add the popcount of chunk i (bits i*K .. i*K+K-1) to the accumulator and then increment i.
REQ-020 Bits at index >= W in the final chunk SHALL be masked to 0 when W mod K != 0.
REQ-021 After chunk NCHUNK-1 is processed, the state SHALL become DONE with out_valid=1, so out_valid rises exactly NCHUNK cycles after the accept edge.
REQ-022 In DONE, out_count, out_match and out_valid SHALL stay stable until out_ready=1.
REQ-023 On the edge where out_valid and out_ready are both high, the state SHALL return to IDLE and out_valid SHALL drop.
REQ-024 Throughput SHALL be one word per NCHUNK+2 cycles at most; there is no overlap of accept and drain.
REQ-025 Classification of count c using the latched sel SHALL be:
 - sel=0: match iff c==0.
 - sel=1: match iff c is a power of two (1,2,4,...).
 - sel=2: match iff c!=0, c is not a power of two, and c<W.
 - sel=3: match iff c==W (all ones).
REQ-026 Where a value qualifies for both sel=1 and sel=3 (c==W and W a power of two), both modes SHALL report a match.
REQ-027 out_match SHALL be computed from the final count and be registered together with out_valid, never combinationally from in_sel.
REQ-028 Changes on in_data, in_sel or in_valid outside IDLE SHALL have no effect.
REQ-029 The accumulator SHALL be CW bits wide and SHALL never overflow, since its maximum value is W.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and in_ready=1, out_valid=0, out_count=0, out_match=0, busy=0.
REQ-031 A reset asserted mid-COUNT or mid-DONE SHALL abort the word immediately, with no result delivered.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Latency check, W=7, K=1: in_data=7'b1011010, sel=1 -> out_valid 7 cycles after accept, out_count=4, out_match=1.
REQ-034 Exhaustive check, W=7, K=1: all 128 words x 4 sel values -> sel=1 matches counts {1,2,4}, sel=2 matches counts {3,5,6}, sel=3 matches count {7}, sel=0 matches count {0}.
REQ-035 Partial-chunk check, W=10, K=4: in_data=10'h3FF, sel=3 -> after 3 cycles out_count=10, out_match=1; garbage bits in the padded chunk must not be counted.
REQ-036 Backpressure check: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE on the next edge.
REQ-037 Reset check: drop rst_n in the 3rd COUNT cycle -> out_valid=0 and in_ready=1 immediately; the next word gives the correct count with no carry-over.
REQ-038 Edge-case check, W=8, K=8: in_data=8'hFF with sel=1 and sel=3 -> out_count=8, out_match=1 for both; in_data=0 with sel=0 -> out_match=1.
